// File: rtl/instr_mem_loader.sv
// Instruction memory loader: takes 32-bit words over valid/ready and writes them as 4 little-endian bytes.
// Latency: first byte strobe 1 cycle after the handshake, one byte per cycle, 1 word per 5 cycles.
// Backpressure: word_ready drops while a word is being written and whenever the next word would not fit.
module instr_mem_loader #(
    parameter int ADDR_W    = 7,
    parameter int MEM_BYTES = 73,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    output logic              word_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_loaded
);

    // Pointer carries one extra bit so ptr+4 can never wrap when testing for room.
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] BASE_P = PW'(BASE_ADDR);
    localparam logic [PW-1:0] MEM_P  = PW'(MEM_BYTES);
    localparam logic [PW-1:0] FOUR_P = PW'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WR0,
        S_WR1,
        S_WR2,
        S_WR3,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [31:0]       word_q, word_d;
    logic              fin_q, fin_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              ready_q, ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              full_q, full_d;

    logic              hs;

    // ready_q is only ever set when the next state is LOAD with room left,
    // so a handshake here always has space for all four bytes.
    assign hs = (state_q == S_LOAD) && word_valid && ready_q;

    // Next-state logic for the session FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        fin_d   = fin_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                // A finish arriving together with start is dropped: the session opens.
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = BASE_P;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    fin_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (word_valid && full_q) begin
                    ovf_d = 1'b1;
                end
                // A word already accepted must still be written, so a finish that
                // coincides with a handshake is held until the word completes.
                if (hs) begin
                    word_d  = word_data;
                    state_d = S_WR0;
                    fin_d   = finish;
                end else if (finish) begin
                    state_d = S_DONE;
                end
            end
            S_WR0: begin
                state_d = S_WR1;
                fin_d   = fin_q | finish;
            end
            S_WR1: begin
                state_d = S_WR2;
                fin_d   = fin_q | finish;
            end
            S_WR2: begin
                state_d = S_WR3;
                fin_d   = fin_q | finish;
            end
            S_WR3: begin
                ptr_d   = ptr_q + FOUR_P;
                cnt_d   = cnt_q + ADDR_W'(1);
                fin_d   = 1'b0;
                state_d = (fin_q || finish) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        full_d    = (ptr_d + FOUR_P) > MEM_P;
        ready_d   = (state_d == S_LOAD) && !full_d;
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        case (state_d)
            S_WR0: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_d[ADDR_W-1:0];
                wr_data_d = word_d[7:0];
            end
            S_WR1: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_d[ADDR_W-1:0] + ADDR_W'(1);
                wr_data_d = word_d[15:8];
            end
            S_WR2: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_d[ADDR_W-1:0] + ADDR_W'(2);
                wr_data_d = word_d[23:16];
            end
            S_WR3: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_d[ADDR_W-1:0] + ADDR_W'(3);
                wr_data_d = word_d[31:24];
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any partial word at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= BASE_P;
            word_q    <= '0;
            fin_q     <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            word_q    <= word_d;
            fin_q     <= fin_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            full_q    <= full_d;
        end
    end

    assign word_ready   = ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign full         = full_q;
    assign overflow     = ovf_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: single word, streaming, fill/overflow, finish mid-word, reset mid-word.
// Captures every byte write on the falling edge and compares against hand-computed addresses/bytes.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_instr_mem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        finish;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        full;
    logic        overflow;
    logic [6:0]  words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [6:0] qa[$];
    logic [7:0] qd[$];

    instr_mem_loader #(
        .ADDR_W   (7),
        .MEM_BYTES(73),
        .BASE_ADDR(0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .finish      (finish),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_ready  (word_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .full        (full),
        .overflow    (overflow),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side capture of every byte strobe.
    always @(negedge clk) begin
        if (wr_en) begin
            qa.push_back(wr_addr);
            qd.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word once the loader is ready, then let its four byte writes run.
    task automatic send(input logic [31:0] w);
        int n = 0;
        while (!word_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", word_ready, 1);
        word_valid = 1'b1;
        word_data  = w;
        tick();
        word_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic chk_word(input string tag, input int idx, input int addr, input logic [31:0] w);
        check({tag, "_count"}, (qa.size() >= idx + 4), 1);
        if (qa.size() >= idx + 4) begin
            for (int k = 0; k < 4; k++) begin
                check({tag, "_addr"}, qa[idx+k], addr + k);
                check({tag, "_data"}, qd[idx+k], w[8*k +: 8]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] sw[3];
    logic [9:0]  rdy_pat;
    int          sidx;
    int          nwr;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        finish     = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        repeat (3) tick();

        // Reset state
        check("rst_ready", word_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_words", words_loaded, 0);
        reset = 1'b0;
        tick();

        // finish in IDLE is ignored
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("idle_fin_busy", busy, 0);
        tick();
        check("idle_fin_done", done, 0);

        // Single word 0xDEADBEEF
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_ready", word_ready, 1);
        word_valid = 1'b1;
        word_data  = 32'hDEADBEEF;
        tick();
        word_valid = 1'b0;
        check("t1_b0_en", wr_en, 1);
        check("t1_b0_addr", wr_addr, 0);
        check("t1_b0_data", wr_data, 8'hEF);
        check("t1_b0_rdy", word_ready, 0);
        tick();
        check("t1_b1_addr", wr_addr, 1);
        check("t1_b1_data", wr_data, 8'hBE);
        tick();
        check("t1_b2_addr", wr_addr, 2);
        check("t1_b2_data", wr_data, 8'hAD);
        tick();
        check("t1_b3_addr", wr_addr, 3);
        check("t1_b3_data", wr_data, 8'hDE);
        tick();
        check("t1_end_en", wr_en, 0);
        check("t1_words", words_loaded, 1);
        check("t1_end_rdy", word_ready, 1);

        // Streaming with word_valid held high
        qa.delete();
        qd.delete();
        sw[0]   = 32'h04030201;
        sw[1]   = 32'hA5B6C7D8;
        sw[2]   = 32'h00000000;
        rdy_pat = 10'b0000100001;
        sidx    = 0;
        word_valid = 1'b1;
        word_data  = sw[0];
        for (int i = 0; i < 10; i++) begin
            logic taken;
            check("t2_ready_pat", word_ready, rdy_pat[i]);
            taken = word_ready;
            tick();
            if (taken) begin
                sidx++;
                word_data = sw[sidx];
            end
        end
        word_valid = 1'b0;
        chk_word("t2_w0", 0, 4, sw[0]);
        chk_word("t2_w1", 4, 8, sw[1]);
        check("t2_words", words_loaded, 3);

        // Fill to 18 words, then overflow
        for (int i = 0; i < 15; i++) begin
            send(32'h10203040 + i);
        end
        check("t3_words", words_loaded, 18);
        check("t3_full", full, 1);
        check("t3_ready", word_ready, 0);
        check("t3_last_addr", qa[qa.size()-1], 71);
        check("t3_last_data", qd[qd.size()-1], 8'h10);
        check("t3_ovf_before", overflow, 0);
        nwr = qa.size();
        word_valid = 1'b1;
        word_data  = 32'hFFFFFFFF;
        repeat (3) tick();
        word_valid = 1'b0;
        check("t3_ovf", overflow, 1);
        check("t3_no_wr", qa.size(), nwr);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        tick();
        check("t3_done_pulse", done, 0);

        // New session after overflow; start while busy; finish during WR1
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_ovf_clr", overflow, 0);
        check("t4_words_clr", words_loaded, 0);
        check("t4_full_clr", full, 0);
        qa.delete();
        qd.delete();
        send(32'h11223344);
        chk_word("t4_w0", 0, 0, 32'h11223344);
        word_valid = 1'b1;
        word_data  = 32'hA1B2C3D4;
        tick();
        word_valid = 1'b0;
        check("t4_wr0_addr", wr_addr, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_wr1_addr", wr_addr, 5);
        check("t4_wr1_busy", busy, 1);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("t4_wr2_addr", wr_addr, 6);
        tick();
        check("t4_wr3_addr", wr_addr, 7);
        check("t4_wr3_done", done, 0);
        tick();
        check("t4_done", done, 1);
        check("t4_done_busy", busy, 0);
        check("t4_done_wren", wr_en, 0);
        tick();
        check("t4_idle_done", done, 0);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_rdy", word_ready, 0);
        check("t4_words", words_loaded, 2);
        chk_word("t4_w1", 4, 4, 32'hA1B2C3D4);

        // Reset during WR2
        start = 1'b1;
        tick();
        start = 1'b0;
        qa.delete();
        qd.delete();
        word_valid = 1'b1;
        word_data  = 32'hCAFEF00D;
        tick();
        word_valid = 1'b0;
        tick();
        tick();
        check("t5_wr2_addr", wr_addr, 2);
        #3;
        reset = 1'b1;
        #1;
        check("t5_rst_wren", wr_en, 0);
        check("t5_rst_busy", busy, 0);
        repeat (3) tick();
        check("t5_no_more_wr", qa.size(), 2);
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(32'h0BADF00D);
        chk_word("t5_reopen", 2, 0, 32'h0BADF00D);
        check("t5_words", words_loaded, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
